bcd_entry_unit: RTL and testbench

Parametrised numeric entry unit for the calculator datapath. It takes debounced key events from the keypad scanner and builds a signed decimal operand of up to DIGITS digits, with sign toggle, backspace, clear and enter. It drives a blank-padded BCD image to the output/display unit. On enter, it converts the operand to a WIDTH-bit two's-complement value for the arithmetic unit, using a sequential multiply-by-ten accumulator. It replaces the fixed six-digit input path and its combinational converter.

---
 rtl/bcd_entry_unit_pkg.sv | 25 ++
 rtl/bcd_entry_unit_mac10.sv | 29 ++
 rtl/bcd_entry_unit.sv | 132 +++++++++++++
 tb/tb_bcd_entry_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_entry_unit_pkg.sv
// rtl/bcd_entry_unit_pkg.sv - shared key codes, blank nibble and entry FSM states
package bcd_entry_unit_pkg;

    localparam logic [3:0] KEY_SIGN     = 4'hA;
    localparam logic [3:0] KEY_BKSP     = 4'hB;
    localparam logic [3:0] KEY_CLR      = 4'hC;
    localparam logic [3:0] KEY_ENT      = 4'hD;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        ENTRY,
        CONVERT,
        DONE
    } entry_state_t;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_entry_unit_mac10.sv
// rtl/bcd_entry_unit_mac10.sv - registered acc*10+digit accumulator with signed result
module bcd_mac10 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             step,
    input  logic [3:0]       digit,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] acc;

    // x10 as shift-add keeps the step a pair of adders instead of a multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= (acc << 3) + (acc << 1) + WIDTH'(digit);
        end
    end

    assign result = (acc == '0) ? '0 : (neg ? -acc : acc);

endmodule

// File: rtl/bcd_entry_unit.sv
// rtl/bcd_entry_unit.sv - signed decimal keypad entry with sequential BCD-to-binary conversion
module bcd_entry_unit
    import bcd_entry_unit_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic [4*DIGITS-1:0]          bcd_disp,
    output logic [4*DIGITS-1:0]          bcd_arith,
    output logic                         neg,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         busy,
    output logic [WIDTH-1:0]             value,
    output logic                         value_valid
);

    localparam int IMG_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [IMG_W-1:0] BLANK_IMG = {DIGITS{BLANK_NIBBLE}};

    if (DIGITS < 1 || DIGITS > 9 ||
        ((WIDTH < 64) && ((64'd1 << (WIDTH - 1)) <= 64'(pow10(DIGITS) - 1)))) begin : g_param_check
        $error("bcd_entry_unit: WIDTH too small for DIGITS, or DIGITS out of 1..9");
    end

    entry_state_t     state;
    logic [CNT_W-1:0] conv_idx;
    logic [3:0]       cur_digit;
    logic             mac_clr;
    logic             mac_step;
    logic [WIDTH-1:0] mac_result;

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (conv_idx == CNT_W'(i)) begin
                cur_digit = bcd_arith[4*i +: 4];
            end
        end
    end

    assign mac_clr  = (state == ENTRY) && key_valid && (key_code == KEY_ENT);
    assign mac_step = (state == CONVERT);

    bcd_mac10 #(.WIDTH(WIDTH)) u_mac10 (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .step   (mac_step),
        .digit  (cur_digit),
        .neg    (neg),
        .result (mac_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ENTRY;
            conv_idx    <= '0;
            bcd_disp    <= BLANK_IMG;
            bcd_arith   <= '0;
            neg         <= 1'b0;
            digit_count <= '0;
            busy        <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                ENTRY: begin
                    if (key_valid) begin
                        if (key_code <= 4'h9) begin
                            if (!(digit_count == '0 && key_code == 4'h0) &&
                                digit_count != CNT_W'(DIGITS)) begin
                                bcd_disp    <= (bcd_disp << 4) | IMG_W'(key_code);
                                bcd_arith   <= (bcd_arith << 4) | IMG_W'(key_code);
                                digit_count <= digit_count + 1'b1;
                            end
                        end else begin
                            case (key_code)
                                KEY_SIGN: neg <= ~neg;
                                KEY_BKSP: begin
                                    if (digit_count != '0) begin
                                        bcd_disp    <= (bcd_disp >> 4) |
                                                       (IMG_W'(BLANK_NIBBLE) << (IMG_W - 4));
                                        bcd_arith   <= bcd_arith >> 4;
                                        digit_count <= digit_count - 1'b1;
                                    end
                                end
                                KEY_CLR: begin
                                    bcd_disp    <= BLANK_IMG;
                                    bcd_arith   <= '0;
                                    neg         <= 1'b0;
                                    digit_count <= '0;
                                end
                                KEY_ENT: begin
                                    state    <= CONVERT;
                                    busy     <= 1'b1;
                                    conv_idx <= CNT_W'(DIGITS - 1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CONVERT: begin
                    // MSB nibble first; unused upper nibbles are zero so they add nothing
                    if (conv_idx == '0) begin
                        state <= DONE;
                    end else begin
                        conv_idx <= conv_idx - 1'b1;
                    end
                end
                DONE: begin
                    value       <= mac_result;
                    value_valid <= 1'b1;
                    bcd_disp    <= BLANK_IMG;
                    bcd_arith   <= '0;
                    neg         <= 1'b0;
                    digit_count <= '0;
                    busy        <= 1'b0;
                    state       <= ENTRY;
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_entry_unit.sv
// tb/tb_bcd_entry_unit.sv - scoreboard bench for bcd_entry_unit with DIGITS=6, WIDTH=32
module tb_bcd_entry_unit;

    localparam int DIGITS = 6;
    localparam int WIDTH  = 32;

    logic                clk;
    logic                reset;
    logic                key_valid;
    logic [3:0]          key_code;
    logic [4*DIGITS-1:0] bcd_disp;
    logic [4*DIGITS-1:0] bcd_arith;
    logic                neg;
    logic [2:0]          digit_count;
    logic                busy;
    logic [WIDTH-1:0]    value;
    logic                value_valid;

    int checks = 0;
    int errors = 0;
    int vv_count = 0;
    logic [WIDTH-1:0] exp_q[$];

    bcd_entry_unit #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .bcd_disp    (bcd_disp),
        .bcd_arith   (bcd_arith),
        .neg         (neg),
        .digit_count (digit_count),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            vv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_value_valid", 64'd1, 64'd0);
            end else begin
                check("sb_value", 64'(value), 64'(exp_q.pop_front()));
            end
        end
    end

    // called just after a rising edge; the key is taken on the next edge
    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_disp"}, 64'(bcd_disp), 64'hFFFFFF);
        check({tag, "_arith"}, 64'(bcd_arith), 64'h0);
        check({tag, "_count"}, 64'(digit_count), 64'd0);
        check({tag, "_neg"}, 64'(neg), 64'd0);
    endtask

    task automatic do_enter(input logic [WIDTH-1:0] exp, input bit poke);
        exp_q.push_back(exp);
        press(4'hD);
        check("busy_after_enter", 64'(busy), 64'd1);
        for (int k = 1; k <= DIGITS + 1; k++) begin
            key_valid = poke && (k == 1 || k == DIGITS + 1);
            key_code  = (k == 1) ? 4'h5 : 4'h3;
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            if (k == DIGITS) begin
                check("vv_before_latency", 64'(value_valid), 64'd0);
                check("busy_before_done", 64'(busy), 64'd1);
            end
        end
        check("vv_at_latency", 64'(value_valid), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("value_at_latency", 64'(value), 64'(exp));
        @(posedge clk);
        #1;
        check("vv_one_cycle", 64'(value_valid), 64'd0);
        check("value_stable", 64'(value), 64'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_value", 64'(value), 64'd0);
        check("reset_vv", 64'(value_valid), 64'd0);
        reset = 1'b0;

        // 1,2,3 enter
        press(4'h1); press(4'h2); press(4'h3);
        check("t1_disp", 64'(bcd_disp), 64'hFFF123);
        check("t1_arith", 64'(bcd_arith), 64'h000123);
        check("t1_count", 64'(digit_count), 64'd3);
        do_enter(32'd123, 1'b0);
        check_blank("t1_after");

        // leading zeros then -4
        press(4'h0); press(4'h0);
        check("t2_lead_zero_count", 64'(digit_count), 64'd0);
        check("t2_lead_zero_disp", 64'(bcd_disp), 64'hFFFFFF);
        press(4'h4); press(4'hA);
        check("t2_count", 64'(digit_count), 64'd1);
        check("t2_neg", 64'(neg), 64'd1);
        check("t2_disp", 64'(bcd_disp), 64'hFFFFF4);
        do_enter(32'hFFFFFFFC, 1'b0);
        check("t2_neg_cleared", 64'(neg), 64'd0);

        // overflow of digit capacity
        repeat (7) press(4'h9);
        check("t3_count", 64'(digit_count), 64'd6);
        check("t3_arith", 64'(bcd_arith), 64'h999999);
        check("t3_disp", 64'(bcd_disp), 64'h999999);
        do_enter(32'd999999, 1'b0);

        // backspace, including one past empty
        press(4'h5); press(4'h6); press(4'hB);
        check("t4_bksp_disp", 64'(bcd_disp), 64'hFFFFF5);
        check("t4_bksp_arith", 64'(bcd_arith), 64'h000005);
        press(4'hB); press(4'hB);
        check_blank("t4_empty");
        press(4'h7);
        check("t4_count", 64'(digit_count), 64'd1);
        check("t4_disp", 64'(bcd_disp), 64'hFFFFF7);
        press(4'hA); press(4'hA);
        check("t4_neg", 64'(neg), 64'd0);
        do_enter(32'd7, 1'b0);

        // clear keeps value
        press(4'h4); press(4'hA); press(4'hC);
        check_blank("clr");
        check("clr_value_kept", 64'(value), 64'd7);

        // negative zero, keys during busy and on the done edge dropped
        press(4'hA);
        check("t5_neg", 64'(neg), 64'd1);
        do_enter(32'd0, 1'b1);
        check_blank("t5_after");

        // reset during conversion
        press(4'h8); press(4'h8);
        press(4'hD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        check_blank("t6_reset");
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_value", 64'(value), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (DIGITS + 3) @(posedge clk);
        #1;
        check("t6_vv_count", 64'(vv_count), 64'd5);
        check("t6_value_after", 64'(value), 64'd0);
        check("t6_busy_after", 64'(busy), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
